// File: rtl/layer_pkg.sv
// Shared definitions for the sparse-accumulate layer stage: default widths,
// controller state encoding and the reserved no-op index.
package layer_pkg;

  localparam int NUM_NODES_DEF = 16;
  localparam int IDX_W_DEF     = 10;
  localparam int W_W_DEF       = 8;
  localparam int ACC_W_DEF     = 16;
  localparam int OUT_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ACT   = 2'd3
  } layer_state_e;

  // All-ones index of the given width; that index marks a no-op beat.
  function automatic logic [31:0] idx_null(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/layer_relu_clip.sv
// ReLU followed by clipping to the unsigned activation range [0, 2^OUT_W-1].
module layer_relu_clip #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [OUT_W-1:0] act
);

  localparam logic signed [ACC_W-1:0] ACT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // Negative -> 0, above range -> all ones, otherwise pass the low bits.
  always_comb begin
    act = acc[OUT_W-1:0];
    if (acc[ACC_W-1])
      act = '0;
    else if (acc > ACT_MAX)
      act = '1;
  end

endmodule

// File: rtl/layer_accum_controller.sv
// Sparse-accumulate layer stage: per frame, preloads biases, adds one weight
// row per active input index, then presents ReLU+clipped activations on a
// registered valid/ready output. The next frame can accumulate while the
// previous result is held downstream.
// Build option: define LAYER_ACC_SATURATE_EN to make every accumulator add
// saturate at the signed ACC_W limits; otherwise adds wrap.
//
//  state | meaning
//  IDLE  | waiting for the first beat of a frame; preloads biases on accept
//  ACCUM | accepting beats, issuing reads, adding returned rows
//  FLUSH | no new beats; the last pending row add lands
//  ACT   | move clipped result to output register when it is free
module layer_accum_controller
  import layer_pkg::*;
#(
  parameter int NUM_NODES = NUM_NODES_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int W_W       = W_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IDX_W-1:0]           in_index,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       w_rd_en,
  output logic [IDX_W-1:0]           w_rd_addr,
  input  logic [NUM_NODES*W_W-1:0]   w_rd_data,
  input  logic                       bias_we,
  input  logic [NUM_NODES*W_W-1:0]   bias_wdata,
  output logic                       out_valid,
  output logic [NUM_NODES*OUT_W-1:0] out_data,
  input  logic                       out_ready
);

  localparam logic [IDX_W-1:0] IDX_NULL = IDX_W'(idx_null(IDX_W));

  layer_state_e state, state_nxt;
  logic rdy_st;
  logic preload;
  logic load_out;
  logic accept;
  logic pend;
  logic [NUM_NODES*OUT_W-1:0] act_all;

  // in_ready is forced low while reset is held so every output reads 0.
  assign in_ready  = rdy_st & ~reset;
  assign accept    = in_valid & in_ready;
  assign w_rd_en   = accept & (in_index != IDX_NULL);
  assign w_rd_addr = w_rd_en ? in_index : '0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    rdy_st    = 1'b0;
    preload   = 1'b0;
    load_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy_st = 1'b1;
        if (in_valid) begin
          preload   = 1'b1;
          state_nxt = in_last ? ST_FLUSH : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        rdy_st = 1'b1;
        if (in_valid && in_last)
          state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_ACT;
      end
      ST_ACT: begin
        if (!out_valid || out_ready) begin
          load_out  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Marks that the weight row requested last cycle is on w_rd_data now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pend <= 1'b0;
    else
      pend <= w_rd_en;
  end

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
    logic signed [W_W-1:0]   bias_q;
    logic signed [W_W-1:0]   wt;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] wt_ext;

    assign wt     = w_rd_data[n*W_W +: W_W];
    assign wt_ext = {{(ACC_W-W_W){wt[W_W-1]}}, wt};

`ifdef LAYER_ACC_SATURATE_EN
    logic signed [ACC_W:0] wide;
    assign wide = {acc_q[ACC_W-1], acc_q} + {wt_ext[ACC_W-1], wt_ext};

    // Clamp when the extra sum bit disagrees with the sign bit.
    always_comb begin
      acc_sum = wide[ACC_W-1:0];
      if (wide[ACC_W] != wide[ACC_W-1])
        acc_sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_sum = acc_q + wt_ext;
`endif

    // Bias register; a write is visible from the following cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        bias_q <= '0;
      else if (bias_we)
        bias_q <= bias_wdata[n*W_W +: W_W];
    end

    // Accumulator: bias preload on first beat, then one row add per read.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        acc_q <= '0;
      else if (preload)
        acc_q <= {{(ACC_W-W_W){bias_q[W_W-1]}}, bias_q};
      else if (pend)
        acc_q <= acc_sum;
    end

    layer_relu_clip #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_relu_clip (
      .acc (acc_q),
      .act (act_all[n*OUT_W +: OUT_W])
    );
  end

  // Output register; a reload in the same cycle as a transfer keeps valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= act_all;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
